// File: rtl/tdm_demux_2x1.sv
// Receive side of a 2:1 TDM link: locks on the A-slot sync marker and steers
// alternating A/B words onto registered per-channel outputs with framing checks.
module tdm_demux_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_A,
  output logic [WIDTH-1:0] out_B,
  output logic             valid_A,
  output logic             valid_B,
  output logic             pair_valid,
  output logic             sel,
  output logic             locked,
  output logic             sync_err
);

  // Handshake: data_in and sync are consumed on every rising edge where
  // in_valid=1; there is no back-pressure, so the sender never stalls.
  // Output pulses (valid_A, valid_B, pair_valid, sync_err) are exactly one
  // cycle wide and mark the cycle in which the matching register changed.

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    EXP_A = 2'd1,
    EXP_B = 2'd2
  } state_t;

  state_t state;

  // sel and locked are pure decodes of the state register, so the full FSM
  // state is visible on the ports without a separate debug output.
  assign sel    = (state == EXP_B);
  assign locked = (state != HUNT);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state      <= HUNT;
      out_A      <= '0;
      out_B      <= '0;
      valid_A    <= 1'b0;
      valid_B    <= 1'b0;
      pair_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      valid_A    <= 1'b0;
      valid_B    <= 1'b0;
      pair_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (sync) begin
              out_A   <= data_in;
              valid_A <= 1'b1;
              state   <= EXP_B;
            end
          end
          EXP_B: begin
            if (!sync) begin
              out_B      <= data_in;
              valid_B    <= 1'b1;
              pair_valid <= 1'b1;
              state      <= EXP_A;
            end else begin
              // B slot missing: the new sync word starts a fresh frame.
              sync_err <= 1'b1;
              out_A    <= data_in;
              valid_A  <= 1'b1;
            end
          end
          EXP_A: begin
            if (sync) begin
              out_A   <= data_in;
              valid_A <= 1'b1;
              state   <= EXP_B;
            end else begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_2x1.sv
// Directed bench for tdm_demux_2x1: one task per scenario, inline checks,
// hand-computed expected values.
module tb_tdm_demux_2x1;

  logic       clock;
  logic       reset_b;
  logic [7:0] data_in;
  logic       in_valid;
  logic       sync;
  logic [7:0] out_A;
  logic [7:0] out_B;
  logic       valid_A;
  logic       valid_B;
  logic       pair_valid;
  logic       sel;
  logic       locked;
  logic       sync_err;

  int errors = 0;
  int checks = 0;

  tdm_demux_2x1 #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset_b    (reset_b),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .sync       (sync),
    .out_A      (out_A),
    .out_B      (out_B),
    .valid_A    (valid_A),
    .valid_B    (valid_B),
    .pair_valid (pair_valid),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks: inputs change on the falling edge, outputs are sampled
  // 1ns after the rising edge that consumed them
  task automatic send(input logic [7:0] d, input logic s);
    @(negedge clock);
    data_in  = d;
    sync     = s;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    in_valid = 1'b0;
    sync     = 1'b0;
    data_in  = 8'hEE;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_b  = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    data_in  = 8'h00;
    @(negedge clock);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    reset_b  = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    data_in  = 8'h00;
    #12;
    checks++; if (out_A !== 8'h00) begin errors++; $display("FAIL reset_out_A got=%h exp=00", out_A); end
    checks++; if (out_B !== 8'h00) begin errors++; $display("FAIL reset_out_B got=%h exp=00", out_B); end
    checks++; if ({valid_A, valid_B, pair_valid, sync_err} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {valid_A, valid_B, pair_valid, sync_err}); end
    checks++; if ({sel, locked} !== 2'b00) begin errors++; $display("FAIL reset_sel_locked got=%b exp=00", {sel, locked}); end
    @(negedge clock);
    reset_b = 1'b1;
  endtask

  task automatic test_full_frame();
    send(8'h11, 1'b1);
    checks++; if (out_A !== 8'h11) begin errors++; $display("FAIL frame_out_A got=%h exp=11", out_A); end
    checks++; if ({valid_A, valid_B, pair_valid, sync_err} !== 4'b1000) begin errors++; $display("FAIL frame_a_pulses got=%b exp=1000", {valid_A, valid_B, pair_valid, sync_err}); end
    checks++; if ({sel, locked} !== 2'b11) begin errors++; $display("FAIL frame_a_sel_locked got=%b exp=11", {sel, locked}); end
    send(8'h22, 1'b0);
    checks++; if (out_B !== 8'h22) begin errors++; $display("FAIL frame_out_B got=%h exp=22", out_B); end
    checks++; if (out_A !== 8'h11) begin errors++; $display("FAIL frame_out_A_hold got=%h exp=11", out_A); end
    checks++; if ({valid_A, valid_B, pair_valid, sync_err} !== 4'b0110) begin errors++; $display("FAIL frame_b_pulses got=%b exp=0110", {valid_A, valid_B, pair_valid, sync_err}); end
    checks++; if ({sel, locked} !== 2'b01) begin errors++; $display("FAIL frame_b_sel_locked got=%b exp=01", {sel, locked}); end
    idle_cycle();
    checks++; if ({valid_A, valid_B, pair_valid, sync_err} !== 4'b0000) begin errors++; $display("FAIL frame_idle_pulses got=%b exp=0000", {valid_A, valid_B, pair_valid, sync_err}); end
  endtask

  task automatic test_hunt_discard();
    apply_reset();
    send(8'h33, 1'b0);
    checks++; if ({locked, sync_err, valid_A, valid_B} !== 4'b0000) begin errors++; $display("FAIL hunt_w1 got=%b exp=0000", {locked, sync_err, valid_A, valid_B}); end
    send(8'h44, 1'b0);
    checks++; if ({locked, sync_err, valid_A, valid_B} !== 4'b0000) begin errors++; $display("FAIL hunt_w2 got=%b exp=0000", {locked, sync_err, valid_A, valid_B}); end
    checks++; if (out_A !== 8'h00) begin errors++; $display("FAIL hunt_discard_out_A got=%h exp=00", out_A); end
    send(8'h55, 1'b1);
    checks++; if (out_A !== 8'h55) begin errors++; $display("FAIL hunt_lock_out_A got=%h exp=55", out_A); end
    checks++; if ({sel, locked, valid_A} !== 3'b111) begin errors++; $display("FAIL hunt_lock_flags got=%b exp=111", {sel, locked, valid_A}); end
  endtask

  task automatic test_missing_b();
    // finish the 55 frame so the FSM sits in EXP_A
    send(8'h66, 1'b0);
    checks++; if ({sel, locked, pair_valid} !== 3'b011) begin errors++; $display("FAIL missb_setup got=%b exp=011", {sel, locked, pair_valid}); end
    send(8'h01, 1'b1);
    checks++; if ({out_A, sync_err, sel} !== {8'h01, 1'b0, 1'b1}) begin errors++; $display("FAIL missb_first_a got=%h/%b/%b exp=01/0/1", out_A, sync_err, sel); end
    send(8'h02, 1'b1);
    checks++; if (out_A !== 8'h02) begin errors++; $display("FAIL missb_out_A got=%h exp=02", out_A); end
    checks++; if ({sync_err, valid_A, pair_valid, sel, locked} !== 5'b11011) begin errors++; $display("FAIL missb_flags got=%b exp=11011", {sync_err, valid_A, pair_valid, sel, locked}); end
    idle_cycle();
    checks++; if ({sync_err, pair_valid, sel} !== 3'b001) begin errors++; $display("FAIL missb_after got=%b exp=001", {sync_err, pair_valid, sel}); end
  endtask

  task automatic test_lost_align();
    send(8'h99, 1'b0);
    checks++; if ({out_B, pair_valid, sel} !== {8'h99, 1'b1, 1'b0}) begin errors++; $display("FAIL lost_setup got=%h/%b/%b exp=99/1/0", out_B, pair_valid, sel); end
    send(8'h77, 1'b0);
    checks++; if ({sync_err, locked, valid_A, valid_B} !== 4'b1000) begin errors++; $display("FAIL lost_flags got=%b exp=1000", {sync_err, locked, valid_A, valid_B}); end
    checks++; if ({out_A, out_B} !== {8'h02, 8'h99}) begin errors++; $display("FAIL lost_hold got=%h/%h exp=02/99", out_A, out_B); end
    idle_cycle();
    checks++; if ({sync_err, locked} !== 2'b00) begin errors++; $display("FAIL lost_after got=%b exp=00", {sync_err, locked}); end
  endtask

  task automatic test_idle_gap();
    send(8'hAA, 1'b1);
    checks++; if ({out_A, valid_A, sel} !== {8'hAA, 1'b1, 1'b1}) begin errors++; $display("FAIL gap_a got=%h/%b/%b exp=aa/1/1", out_A, valid_A, sel); end
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      checks++; if ({valid_A, valid_B, pair_valid, sync_err, sel, locked} !== 6'b000011) begin errors++; $display("FAIL gap_idle%0d got=%b exp=000011", i, {valid_A, valid_B, pair_valid, sync_err, sel, locked}); end
    end
    send(8'hBB, 1'b0);
    checks++; if ({out_A, out_B} !== {8'hAA, 8'hBB}) begin errors++; $display("FAIL gap_outs got=%h/%h exp=aa/bb", out_A, out_B); end
    checks++; if ({valid_B, pair_valid, sync_err} !== 3'b110) begin errors++; $display("FAIL gap_b_pulses got=%b exp=110", {valid_B, pair_valid, sync_err}); end
    idle_cycle();
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL gap_pair_width got=%b exp=0", pair_valid); end
  endtask

  task automatic test_async_reset();
    send(8'hC1, 1'b1);
    checks++; if ({sel, locked, out_A} !== {1'b1, 1'b1, 8'hC1}) begin errors++; $display("FAIL areset_setup got=%b/%b/%h exp=1/1/c1", sel, locked, out_A); end
    #2;
    reset_b  = 1'b0;
    in_valid = 1'b0;
    #1;
    // still mid-cycle: no clock edge since reset went low
    checks++; if ({out_A, out_B} !== 16'h0000) begin errors++; $display("FAIL areset_outs got=%h/%h exp=00/00", out_A, out_B); end
    checks++; if ({valid_A, valid_B, pair_valid, sync_err, sel, locked} !== 6'b000000) begin errors++; $display("FAIL areset_flags got=%b exp=000000", {valid_A, valid_B, pair_valid, sync_err, sel, locked}); end
    @(negedge clock);
    reset_b = 1'b1;
    send(8'hD1, 1'b1);
    send(8'hD2, 1'b0);
    checks++; if ({out_A, out_B, pair_valid, locked} !== {8'hD1, 8'hD2, 1'b1, 1'b1}) begin errors++; $display("FAIL areset_relock got=%h/%h/%b/%b exp=d1/d2/1/1", out_A, out_B, pair_valid, locked); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hunt_discard();
    test_missing_b();
    test_lost_align();
    test_idle_gap();
    test_async_reset();
    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
